// File: rtl/counter_seq_ctrl_if.sv
// Host/counter-side bundle of the counter sequencer: control, config, counter feedback and sequencer outputs.
// The master drives control, config and counter feedback; the slave is the sequencer itself.
interface counter_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
);
    logic              ena;
    logic              start;
    logic              stop;
    logic              pause;
    logic [WIDTH-1:0]  cfg_start;
    logic [WIDTH-1:0]  cfg_end;
    logic [PASS_W-1:0] cfg_passes;
    logic [WIDTH-1:0]  cnt_val;
    logic              cnt_load;
    logic [WIDTH-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pass_cnt;

    modport master (
        output ena, start, stop, pause, cfg_start, cfg_end, cfg_passes, cnt_val,
        input  cnt_load, cnt_load_val, cnt_en, busy, done, pass_cnt
    );

    modport slave (
        input  ena, start, stop, pause, cfg_start, cfg_end, cfg_passes, cnt_val,
        output cnt_load, cnt_load_val, cnt_en, busy, done, pass_cnt
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for an 8-bit loadable up-counter: load a start value, count to an end value,
// repeat for a programmed number of passes, with pause, abort and a global enable freeze.
module counter_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    counter_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e            state_q,    state_d;
    logic [WIDTH-1:0]  start_q,    start_d;
    logic [WIDTH-1:0]  end_q,      end_d;
    logic [PASS_W-1:0] passes_q,   passes_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [WIDTH-1:0]  load_val_q, load_val_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic              at_end_s;
    logic              more_passes_s;
    logic [PASS_W:0]   pass_inc_s;
    logic              cnt_en_s;
    logic              cnt_load_s;

    // End-of-pass compare and pass bookkeeping; one extra bit keeps the "pass_cnt+1 < passes" test free of wrap.
    always_comb begin
        at_end_s      = (bus.cnt_val == end_q);
        pass_inc_s    = {1'b0, pass_cnt_q} + {{PASS_W{1'b0}}, 1'b1};
        more_passes_s = (passes_q == {PASS_W{1'b0}}) || (pass_inc_s < {1'b0, passes_q});
    end

    // Next-state and next-register computation; ena low freezes everything.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        end_d      = end_q;
        passes_d   = passes_q;
        pass_cnt_d = pass_cnt_q;
        load_val_d = load_val_q;
        if (!bus.ena) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d    = ST_LOAD;
                        start_d    = bus.cfg_start;
                        end_d      = bus.cfg_end;
                        passes_d   = bus.cfg_passes;
                        pass_cnt_d = {PASS_W{1'b0}};
                        load_val_d = bus.cfg_start;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (at_end_s) begin
                        pass_cnt_d = pass_inc_s[PASS_W-1:0];
                        state_d    = more_passes_s ? ST_LOAD : ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (!bus.pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    // Counter strobes must react within the cycle to ena, stop, pause and the live counter value.
    always_comb begin
        cnt_load_s = bus.ena && !bus.stop && (state_q == ST_LOAD);
        cnt_en_s   = bus.ena && !bus.stop && !bus.pause && (state_q == ST_RUN) && !at_end_s;
    end

    // State, latched configuration and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            start_q    <= {WIDTH{1'b0}};
            end_q      <= {WIDTH{1'b0}};
            passes_q   <= {PASS_W{1'b0}};
            pass_cnt_q <= {PASS_W{1'b0}};
            load_val_q <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            end_q      <= end_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            load_val_q <= load_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.cnt_load     = cnt_load_s;
    assign bus.cnt_load_val = load_val_q;
    assign bus.cnt_en       = cnt_en_s;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass_cnt     = pass_cnt_q;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the 8-bit loadable up-counter (load, load value, enable; wraps 0xFF->0x00). It loads a programmed start value, enables counting until a programmed end value is reached, and optionally repeats for N passes. It also supports pause, abort and a global enable freeze. It sits between the host control inputs and the counter's load/enable pins.

Parameters:
WIDTH, 8, counter/value width
PASS_W, 4, width of pass count; cfg_passes==0 means run until stop

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes FSM and all outputs except busy/done hold
start  in  1  start request, sampled in IDLE only
stop  in  1  abort request
pause  in  1  level; high holds counting
cfg_start  in  WIDTH  value loaded at start of each pass
cfg_end  in  WIDTH  terminal value of each pass
cfg_passes  in  PASS_W  number of passes (0 = continuous)
cnt_val  in  WIDTH  current counter value (registered counter output)
cnt_load  out  1  counter load strobe
cnt_load_val  out  WIDTH  value to load
cnt_en  out  1  counter increment enable
busy  out  1  high in LOAD/RUN/PAUSE
done  out  1  one-cycle pulse on normal completion
pass_cnt  out  PASS_W  completed passes since last start

Behaviour:
- Reset (async, rst_n low): state IDLE; cnt_load=0, cnt_load_val=0, cnt_en=0, busy=0, done=0, pass_cnt=0, latched config=0. Reset mid-run aborts immediately; no done pulse.
- Config (cfg_start, cfg_end, cfg_passes) is latched on the accepted start edge. Later changes are ignored until the next start.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE: start=1 -> LOAD, pass_cnt cleared. stop is ignored.
- LOAD: cnt_load=1 and cnt_load_val=latched start for exactly one cycle, cnt_en=0. Next state RUN; the counter shows the start value in the first RUN cycle.
- RUN, cnt_val != end: cnt_en=1 (combinational from state and compare).
- RUN, cnt_val == end: cnt_en=0 and pass_cnt+1.
  - If cfg_passes==0, or pass_cnt+1 < cfg_passes: next state LOAD.
  - Otherwise: next state DONE.
- RUN, pause=1 -> PAUSE with cnt_en=0 that cycle. PAUSE holds with cnt_en=0 until pause=0, then RUN.
- DONE: done=1 and busy=0 for one cycle, then IDLE. cnt_val is left at cfg_end.
- stop=1 in LOAD/RUN/PAUSE -> IDLE next edge, cnt_en=0 that cycle, no done, pass_cnt holds.
- Priority within one cycle: rst_n > ena low > stop > pause > end-of-pass compare > normal count.
- ena=0: state, pass_cnt and latched config hold; cnt_load=0 and cnt_en=0. On return, the FSM resumes in the same state.
- start while busy is ignored. A start pulse coincident with DONE is ignored.
- Wrap-around: cfg_end < cfg_start is legal; the counter passes through 0xFF->0x00. cfg_end == cfg_start gives a zero-increment pass: end is detected in the first RUN cycle.
- pass_cnt wraps modulo 2^PASS_W in continuous mode.
- Single-pass latency: LOAD plus (end-start mod 2^WIDTH)+1 RUN cycles, then DONE.

Test Plan:
- Single pass: start 0x10, end 0x14, passes 1 -> one cnt_load with 0x10; cnt_en high 4 cycles; counter holds 0x14. done pulses on the 6th edge after the start edge; pass_cnt=1, busy low after.
- Wrap: start 0xFD, end 0x02, passes 1 -> counter sequence FD,FE,FF,00,01,02; cnt_en high 5 cycles; then done.
- Multi-pass: start 0x2B, end 0x2D, passes 3 -> exactly 3 cnt_load strobes; pass_cnt steps 1,2,3; single done after the third pass.
- Pause/ena freeze: pause for 10 cycles at cnt_val=0x12 -> value holds 0x12, busy=1, then counting resumes. Then ena=0 for 10 cycles -> no cnt_en/cnt_load, state preserved.
- Abort/reset: stop at cnt_val=0x11 -> IDLE next cycle, no done, counter holds 0x11. start during RUN is ignored. rst_n low mid-RUN -> all outputs 0 immediately.
- Continuous: passes 0, start 0x00, end 0x01 for 20 passes -> load strobe every 3 cycles; pass_cnt wraps 15->0; runs until stop.
